// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter: FSM encoding, parameter defaults
// and the grant-index width helper.
package rr_arb_pkg;

    localparam int unsigned NDefault       = 8;
    localparam int unsigned HoldMaxDefault = 16;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } state_e;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_mask_pe.sv
// Masked LSB-first priority encoder: prefers requesters strictly above last_id,
// and wraps to the lowest requester overall when none are above it.
module rr_mask_pe
    import rr_arb_pkg::*;
#(
    parameter int unsigned N = NDefault,
    parameter int unsigned W = idx_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_id,
    output logic [W-1:0] sel_id,
    output logic         any_req
);

    logic [N-1:0] masked;
    logic [N-1:0] cand;

    // Build the rotation mask, choose masked or wrapped candidates, then find the lowest set bit.
    always_comb begin
        masked = '0;
        for (int i = 0; i < int'(N); i++) begin
            masked[i] = req[i] && (i > int'(last_id));
        end
        cand   = (|masked) ? masked : req;
        sel_id = '0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_id = W'(i);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/rr_arb_8b.sv
// Round-robin arbiter for N requesters with registered one-hot grant, grant hold
// until release (done or withdrawal) and rotating priority.
// Optional feature: define RR_TIMEOUT_EN to force-release a grant held for HOLD_MAX cycles.
module rr_arb_8b
    import rr_arb_pkg::*;
#(
    parameter int unsigned N        = NDefault,
    parameter int unsigned W        = idx_width(N),
    parameter int unsigned HOLD_MAX = HoldMaxDefault
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_id,
    output logic         gnt_val,
    output logic         timeout
);

    state_e         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [W-1:0]   gnt_id_q, gnt_id_d;
    logic [W-1:0]   last_id_q, last_id_d;
    logic [W-1:0]   sel_id;
    logic           any_req;
    logic           load;
    logic           release_w;
    logic           force_rel;

    rr_mask_pe #(
        .N (N),
        .W (W)
    ) u_pe (
        .req     (req),
        .last_id (last_id_q),
        .sel_id  (sel_id),
        .any_req (any_req)
    );

    assign release_w = done | ~req[gnt_id_q] | force_rel;

    // Next-state: grant from idle, or on release re-arbitrate without a bubble.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        last_id_d = last_id_q;
        load      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    load = 1'b1;
                end
            end
            StGrant: begin
                if (release_w) begin
                    if (any_req) begin
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (load) begin
            state_d   = StGrant;
            gnt_d     = {{(N-1){1'b0}}, 1'b1} << sel_id;
            gnt_id_d  = sel_id;
            last_id_d = sel_id;
        end
    end

    // State and grant registers; reset drops any grant immediately.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            last_id_q <= W'(N - 1);
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            last_id_q <= last_id_d;
        end
    end

`ifdef RR_TIMEOUT_EN
    localparam int unsigned CW = $clog2(HOLD_MAX) + 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    // Hold counter: restarts on every new grant, counts grant cycles, idles at zero.
    always_comb begin
        force_rel = (state_q == StGrant) && (cnt_q == CW'(HOLD_MAX - 1));
        cnt_d     = cnt_q;
        if (load || (state_d == StIdle)) begin
            cnt_d = '0;
        end else if (state_q == StGrant) begin
            cnt_d = cnt_q + CW'(1);
        end
        // Only flag releases the counter caused, not ones done/withdrawal caused anyway.
        timeout_d = force_rel && !done && req[gnt_id_q];
    end

    // Counter and timeout pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_hold_max;
    assign unused_hold_max = ^HOLD_MAX;
    assign force_rel       = 1'b0;
    assign timeout         = 1'b0;
`endif

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign gnt_val = (state_q == StGrant);

endmodule

// File: doc/rr_arb_8b.md
Name: rr_arb_8b

Overview:
- Round-robin arbiter that shares one downstream resource (a priority-encoded service slot) among 8 requesters.
- Wraps a masked LSB-first priority encoder and adds grant registering, grant hold until release, and rotating fairness.
- Sits between the requester bank and the shared datapath. Its registered one-hot grant and grant index drive the resource's select mux.

Parameters:
N, 8, number of requesters (power of two, 2..16)
W, $clog2(N), width of the grant index
HOLD_MAX, 16, max cycles one grant is held; used only with RR_TIMEOUT_EN

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
req  input  N  request vector, bit i = requester i, level-sensitive
done  input  1  current grantee finished, single-cycle pulse
gnt  output  N  registered one-hot grant
gnt_id  output  W  registered index of granted requester
gnt_val  output  1  a grant is active (equals |gnt)
timeout  output  1  one-cycle pulse when a grant is force-released (0 without RR_TIMEOUT_EN)

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-low (rst_n).
- Reset state, when rst_n=0 at a rising edge:
  - gnt=0, gnt_id=0, gnt_val=0, timeout=0.
  - state=IDLE, last_id=N-1, so index 0 has first priority.
  - Reset mid-grant drops the grant at that edge. No cleanup cycle.
- Selection, combinational:
  - mask = bits strictly above last_id.
  - If req&mask is nonzero, pick the lowest set index of req&mask. Otherwise pick the lowest set index of req (wrap).
  - any_req = |req.
- State IDLE:
  - gnt_val=0.
  - If any_req, go to GRANT at the next edge with the selected index, and load gnt/gnt_id/last_id.
  - Latency: req high at edge k gives gnt at edge k+1.
  - done is ignored in IDLE.
- State GRANT:
  - Grant is held constant while req[gnt_id]=1 and done=0.
  - Release condition: done=1, or req[gnt_id]=0 (requester withdrew).
  - On the release edge:
    - If any_req, re-arbitrate immediately with no bubble, using the updated last_id = current gnt_id. The released requester therefore has lowest priority. If it is the only requester still asserting, it is regranted.
    - Otherwise go to IDLE and clear gnt.
- Arbitration uses req sampled at the same edge; requests are not latched.
- A request that deasserts before it is granted is simply lost.
- gnt is always one-hot or zero. gnt_id is held at its last value while in IDLE; gnt_val qualifies it.
- Simultaneous done and new requests: release and the new grant take effect on the same edge.

Optional Feature:
- Macro: RR_TIMEOUT_EN.
- Defined:
  - A hold counter clears on every new grant and increments each GRANT cycle.
  - When the counter reaches HOLD_MAX-1 with no release, force a release on the next edge, exactly like done=1.
  - timeout pulses high for the cycle after the forced release edge.
  - The counter resets to 0.
- Undefined:
  - No counter logic. timeout is tied to 0.
  - A grantee may hold indefinitely.

Decomposition:
- Shared package rr_arb_pkg:
  - state encoding: IDLE=1'b0, GRANT=1'b1.
  - defaults for N, HOLD_MAX.
  - a localparam function for the index width.
- One sub-module, rr_mask_pe:
  - combinational masked/unmasked LSB-first priority encoder.
  - inputs: req, last_id. Outputs: sel_id, any_req.
- The top module holds the FSM, output registers and optional counter.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks with req=8'hFF -> gnt=0, gnt_val=0, gnt_id=0. Release reset -> next edge gnt=8'h01, gnt_id=0.
- Single requester: req=8'b00000100, pulse done after 3 cycles -> gnt=8'h04, gnt_id=2 for 3 cycles. Because req[2] stays high and is the only requester, it is regranted.
- Rotation: req=8'hFF with done every cycle -> gnt_id sequence 0,1,2,...,7,0. No bubble cycles, gnt_val stays 1.
- Withdrawal and wrap:
  - Grant at id 6, then req=8'b00000011 with req[6] dropped -> next gnt_id=0 (wrap), then after done gnt_id=1.
  - req=0 -> IDLE, gnt_val=0.
- Simultaneous: req=8'b01000100 during a grant at id 2, pulse done -> next edge gnt_id=6 (higher than last_id 2 beats wrap).
- RR_TIMEOUT_EN, HOLD_MAX=16: req=8'h01 constant, no done -> grant held for 16 cycles, then forced release and regrant of id 0, timeout pulses once. Without the macro, timeout stays 0 and the grant holds.
